debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Multi-channel, parametrised debounce filter for mechanical switches and buttons. Successor to the single-channel debounce filter.
- Each of NUM_CH asynchronous bouncy inputs passes through a 2-flop synchroniser, then a per-channel stability counter.
- Outputs per channel: debounced level, one-cycle rise/fall strobes and a one-cycle "any change" flag.
- Sits between board switch pins and user logic (LED toggles, state machines, counters).

Parameters:
- NUM_CH, 4, number of independent input channels (>=1).
- DEBOUNCE_LIMIT, 250000, consecutive stable synchronised cycles required to accept a new level (>=2).
- HOLD_LIMIT, 25000000, cycles the debounced level must stay high before a hold strobe (>=2; used only with DEBOUNCE_HOLD_EN).

Ports:
- i_Clk  input  1  system clock; all logic on posedge.
- i_Rst  input  1  synchronous, active-high reset.
- i_Bouncy  input  NUM_CH  raw asynchronous switch levels; bit n = channel n.
- o_Debounced  output  NUM_CH  filtered level per channel.
- o_Rise  output  NUM_CH  one-cycle strobe: channel accepted 0->1.
- o_Fall  output  NUM_CH  one-cycle strobe: channel accepted 1->0.
- o_Changed  output  1  OR-reduction of o_Rise|o_Fall, same cycle.
- o_Hold  output  NUM_CH  one-cycle long-press strobe (optional feature).

Behaviour:
- Reset (i_Rst high at a posedge):
  - Clears synchroniser flops, debounce counters, hold counters and all registered outputs.
  - o_Debounced = 0; o_Rise = o_Fall = o_Hold = 0; o_Changed = 0.
  - Reset overrides everything in the same edge. Mid-operation reset discards partial counts.
  - An input already high when reset releases is re-debounced from count 0.
- Synchroniser: sync1 <= i_Bouncy[n]; sync2 <= sync1. Only sync2 feeds the filter.
- Counter per channel, width $clog2(DEBOUNCE_LIMIT), minimum 1:
  - sync2 != state and count < DEBOUNCE_LIMIT-1: count increments.
  - sync2 != state and count == DEBOUNCE_LIMIT-1: state <= sync2; count <= 0.
  - sync2 == state: count <= 0. Any single-cycle bounce restarts the count.
- Latency: the posedge that first samples a new i_Bouncy level is edge k. o_Debounced changes after edge k+1+DEBOUNCE_LIMIT, provided the level is held through that edge.
- Strobes: o_Rise/o_Fall are registered and asserted for exactly the one cycle following the state update; otherwise 0. Rise and fall never assert together on one channel.
- Channels are fully independent. Simultaneous transitions on several channels give simultaneous strobes; o_Changed is a single cycle.
- Counter never wraps; it is reset on the accept edge.

Optional Feature:
- Macro: DEBOUNCE_HOLD_EN.
- Defined:
  - Each channel has a hold counter, width $clog2(HOLD_LIMIT).
  - The counter increments while o_Debounced[n] = 1 and clears when it is 0.
  - When the count reaches HOLD_LIMIT-1, o_Hold[n] pulses for one cycle and the counter saturates. No repeat pulse until the level falls and rises again.
  - Reset clears the hold counters.
- Undefined: no hold counters are built; the o_Hold port remains and is tied to 0.

Decomposition:
- Package debounce_pkg:
  - Width helper function (clog2 with minimum 1).
  - Default limit constants: DEBOUNCE_LIMIT_DEFAULT and HOLD_LIMIT_DEFAULT.
- Sub-module debounce_channel:
  - Contains the synchroniser, stability counter, state, rise/fall strobes and optional hold logic for one bit.
  - Instantiated NUM_CH times via generate.
- The top level holds only the generate loop and the o_Changed OR-reduction.

Test Plan (NUM_CH=4, DEBOUNCE_LIMIT=4, HOLD_LIMIT=8, 2 ns half-period):
- Reset held 3 cycles with i_Bouncy=4'b1111 -> all outputs 0 during reset. After release, o_Debounced=4'b1111 after edge k+5 counted from the first post-reset edge (k), with o_Rise=4'b1111 and o_Changed=1 for one cycle.
- Ch0 high 1 cycle, low 1 cycle, then high 6 cycles -> o_Debounced[0] rises exactly 5 edges after the final high is first sampled. Single o_Rise[0] pulse; no fall pulse.
- Ch1 high for 3 cycles only (< limit) -> o_Debounced[1] stays 0; no strobes.
- Ch2 debounced high, then driven low stable -> o_Fall[2] pulses once, 5 edges after the low is first sampled. o_Debounced[2]=0.
- Ch0 and ch3 rise on the same edge -> o_Rise=4'b1001 in one cycle; o_Changed is a single one-cycle pulse.
- With DEBOUNCE_HOLD_EN, ch0 held high 20 cycles -> exactly one o_Hold[0] pulse, 8 cycles after o_Debounced[0] rose.
- Without DEBOUNCE_HOLD_EN, the same stimulus -> o_Hold stays 0.
- Reset asserted mid-count on ch1 -> count discarded; debounce restarts from 0 after release.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the multi-channel debounce filter.
package debounce_pkg;

    localparam int DEBOUNCE_LIMIT_DEFAULT = 250000;
    localparam int HOLD_LIMIT_DEFAULT     = 25000000;

    // Counter width for a given limit, never narrower than one bit.
    function automatic int clog2Min1(input int value);
        int width;
        width = $clog2(value);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, stability counter, level, rise/fall strobes.
// Long-press hold strobe is built only when DEBOUNCE_HOLD_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
    parameter int HOLD_LIMIT     = HOLD_LIMIT_DEFAULT
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Bouncy,
    output logic o_Debounced,
    output logic o_Rise,
    output logic o_Fall,
    output logic o_Hold
);

    localparam int              CntW    = clog2Min1(DEBOUNCE_LIMIT);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_LIMIT - 1);

    logic            sync1_q, sync2_q;
    logic            state_q, state_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic [CntW-1:0] count_q, count_d;

    // Any cycle where the synchronised input agrees with the accepted level restarts the count.
    always_comb begin
        state_d = state_q;
        count_d = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != state_q) begin
            if (count_q == CntLast) begin
                state_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            count_q <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= i_Bouncy;
            sync2_q <= sync1_q;
            state_q <= state_d;
            count_q <= count_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_Debounced = state_q;
    assign o_Rise      = rise_q;
    assign o_Fall      = fall_q;

`ifdef DEBOUNCE_HOLD_EN
    localparam int               HoldW    = clog2Min1(HOLD_LIMIT);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_LIMIT - 1);

    logic [HoldW-1:0] holdCount_q, holdCount_d;
    logic             holdFired_q, holdFired_d;
    logic             hold_q, hold_d;

    // Counter saturates at its last value; the fired flag blocks a repeat until the level drops.
    always_comb begin
        holdCount_d = holdCount_q;
        holdFired_d = holdFired_q;
        hold_d      = 1'b0;
        if (!state_q) begin
            holdCount_d = '0;
            holdFired_d = 1'b0;
        end else if (holdCount_q != HoldLast) begin
            holdCount_d = holdCount_q + HoldW'(1);
        end else if (!holdFired_q) begin
            hold_d      = 1'b1;
            holdFired_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            holdCount_q <= '0;
            holdFired_q <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            holdCount_q <= holdCount_d;
            holdFired_q <= holdFired_d;
            hold_q      <= hold_d;
        end
    end

    assign o_Hold = hold_q;
`else
    localparam int HoldW = clog2Min1(HOLD_LIMIT);

    logic [HoldW-1:0] unusedHoldLast;
    assign unusedHoldLast = HoldW'(HOLD_LIMIT - 1);
    assign o_Hold         = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debounce filter: NUM_CH independent lanes plus a shared change flag.
// Optional long-press strobe on o_Hold is enabled by defining DEBOUNCE_HOLD_EN.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
    parameter int HOLD_LIMIT     = HOLD_LIMIT_DEFAULT
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_CH-1:0] i_Bouncy,
    output logic [NUM_CH-1:0] o_Debounced,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic              o_Changed,
    output logic [NUM_CH-1:0] o_Hold
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gChannel
        debounce_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .HOLD_LIMIT     (HOLD_LIMIT)
        ) uChannel (
            .i_Clk       (i_Clk),
            .i_Rst       (i_Rst),
            .i_Bouncy    (i_Bouncy[ch]),
            .o_Debounced (o_Debounced[ch]),
            .o_Rise      (o_Rise[ch]),
            .o_Fall      (o_Fall[ch]),
            .o_Hold      (o_Hold[ch])
        );
    end

    // Strobes are already registered, so this flag lines up with them in the same cycle.
    assign o_Changed = |(o_Rise | o_Fall);

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: sliding-window reference model, directed plus random stimulus.
module tb_debounce_multi;

    localparam int NumCh     = 4;
    localparam int DebLimit  = 4;
    localparam int HoldLimit = 8;
    localparam int MaxEdges  = 4096;

    typedef struct packed {
        logic [NumCh-1:0] debounced;
        logic [NumCh-1:0] rise;
        logic [NumCh-1:0] fall;
        logic             changed;
        logic [NumCh-1:0] hold;
    } outVec_t;

    logic             clock = 1'b0;
    logic             rst;
    logic [NumCh-1:0] bouncy;
    logic [NumCh-1:0] debounced, rise, fall, hold;
    logic             changed;

    debounce_multi #(
        .NUM_CH         (NumCh),
        .DEBOUNCE_LIMIT (DebLimit),
        .HOLD_LIMIT     (HoldLimit)
    ) dut (
        .i_Clk       (clock),
        .i_Rst       (rst),
        .i_Bouncy    (bouncy),
        .o_Debounced (debounced),
        .o_Rise      (rise),
        .o_Fall      (fall),
        .o_Changed   (changed),
        .o_Hold      (hold)
    );

    always #2 clock = ~clock;

    outVec_t          expQ[$];
    int               vectors    = 0;
    int               miscompares = 0;
    int               pushed     = 0;
    int               edgeIdx    = 0;
    logic [NumCh-1:0] mState     = '0;
    int               runLen[NumCh];
    logic [NumCh-1:0] inHist[MaxEdges];
    bit               rstHist[MaxEdges];

    function automatic bit rstAt(input int e);
        return (e < 0) ? 1'b1 : rstHist[e];
    endfunction

    function automatic logic [NumCh-1:0] inAt(input int e);
        return (e < 0) ? '0 : inHist[e];
    endfunction

    // A level is accepted at an edge when the input sampled DebLimit+1..2 edges earlier
    // held the new value throughout, with no reset touching that window.
    task automatic modelEdge(input logic r, input logic [NumCh-1:0] v);
        outVec_t          e;
        logic [NumCh-1:0] past;
        logic             target;
        bit               stable;
        int               ee;
        e = '0;
        if (edgeIdx >= MaxEdges) begin
            $display("[TB] FAIL edgeBudget: got %0d edges, limit %0d", edgeIdx, MaxEdges);
            $fatal(1, "[TB] edge budget exhausted");
        end
        rstHist[edgeIdx] = r;
        inHist[edgeIdx]  = r ? '0 : v;
        if (r) begin
            mState = '0;
            foreach (runLen[c]) runLen[c] = 0;
        end else begin
            for (int c = 0; c < NumCh; c++) begin
                target = ~mState[c];
                stable = 1'b1;
                for (int j = 0; j < DebLimit; j++) begin
                    ee   = edgeIdx - j;
                    past = inAt(ee - 2);
                    if (rstAt(ee) || rstAt(ee - 1) || past[c] != target) stable = 1'b0;
                end
`ifdef DEBOUNCE_HOLD_EN
                e.hold[c] = (runLen[c] == HoldLimit);
`endif
                if (stable) begin
                    mState[c] = target;
                    e.rise[c] = target;
                    e.fall[c] = ~target;
                end
                runLen[c] = mState[c] ? runLen[c] + 1 : 0;
            end
        end
        e.debounced = mState;
        e.changed   = |(e.rise | e.fall);
        expQ.push_back(e);
        pushed++;
        edgeIdx++;
    endtask

    task automatic applyStimulus(input logic r, input logic [NumCh-1:0] v, input int n);
        repeat (n) begin
            @(negedge clock);
            rst    = r;
            bouncy = v;
            @(posedge clock);
            modelEdge(r, v);
        end
    endtask

    task automatic checkOutput(input string name, input logic [NumCh-1:0] act,
                               input logic [NumCh-1:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at vector %0d: got %b, expected %b", name, vectors, act, exp);
        end
    endtask

    // Monitor: outputs settle after each posedge, so compare one entry per falling edge.
    initial begin
        outVec_t e;
        forever begin
            @(negedge clock);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                vectors++;
                checkOutput("debounced", debounced, e.debounced);
                checkOutput("rise", rise, e.rise);
                checkOutput("fall", fall, e.fall);
                checkOutput("changed", NumCh'(changed), NumCh'(e.changed));
                checkOutput("hold", hold, e.hold);
            end
        end
    end

    initial begin
        logic [NumCh-1:0] cur;
        logic             r;
        int               div;
        int               guard;
        rst    = 1'b1;
        bouncy = '0;

        // Inputs high through reset, then re-debounced from zero.
        applyStimulus(1'b1, 4'b1111, 3);
        applyStimulus(1'b0, 4'b1111, 10);
        applyStimulus(1'b0, 4'b0000, 10);
        // Ch0 bounce then a stable high.
        applyStimulus(1'b0, 4'b0001, 1);
        applyStimulus(1'b0, 4'b0000, 1);
        applyStimulus(1'b0, 4'b0001, 10);
        // Ch1 pulse shorter than the limit.
        applyStimulus(1'b0, 4'b0011, 3);
        applyStimulus(1'b0, 4'b0001, 8);
        // Ch2 up, then down.
        applyStimulus(1'b0, 4'b0101, 10);
        applyStimulus(1'b0, 4'b0001, 10);
        // Ch0 and ch3 rising together, then a long press on ch0.
        applyStimulus(1'b0, 4'b0000, 10);
        applyStimulus(1'b0, 4'b1001, 30);
        applyStimulus(1'b0, 4'b0000, 10);
        applyStimulus(1'b0, 4'b0001, 25);
        // Reset in the middle of a ch1 count.
        applyStimulus(1'b0, 4'b0011, 3);
        applyStimulus(1'b1, 4'b0011, 1);
        applyStimulus(1'b0, 4'b0011, 12);

        cur = 4'b0011;
        for (int blk = 0; blk < 40; blk++) begin
            case ($urandom_range(2))
                0:       div = 3;
                1:       div = 8;
                default: div = 30;
            endcase
            for (int n = 0; n < 50; n++) begin
                for (int c = 0; c < NumCh; c++)
                    if ($urandom_range(div - 1) == 0) cur[c] = ~cur[c];
                r = ($urandom_range(149) == 0);
                applyStimulus(r, cur, 1);
            end
        end

        guard = 0;
        while (expQ.size() > 0 && guard < 10) begin
            @(negedge clock);
            #1;
            guard++;
        end
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d entries left, expected 0", expQ.size());
        end
        if (vectors != pushed) begin
            miscompares++;
            $display("[TB] FAIL vectorCount: got %0d checked, expected %0d", vectors, pushed);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
